// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, special encodings and operand unpacking.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   sig;
  } fp_unpacked_t;

  // Split a binary32 word; zero and subnormal exponents give a zero significand.
  // The sign can be flipped so subtraction becomes an addition of -b.
  function automatic fp_unpacked_t unpack(input logic [31:0] x, input logic flip);
    fp_unpacked_t u;
    u.sign = x[31] ^ flip;
    u.exp  = x[30:23];
    u.sig  = (x[30:23] == 8'd0) ? '0 : {1'b1, x[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp32_add_sub_if.sv
// Operand/result bundle between the operand registers and the adder.
interface fp32_add_sub_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  symbol;
  logic [DATA_WIDTH-1:0] out;

  modport master (output a, output b, output symbol, input out);
  modport slave  (input a, input b, input symbol, output out);
endinterface

// File: rtl/lzc24.sv
// Leading-zero counter for the 24-bit significand plus guard/round/sticky.
module lzc24 #(
  parameter int W = 27
) (
  input  logic [W-1:0] val_i,
  output logic [4:0]   cnt_o
);

  // Scan upward so the most significant set bit is the last one to assign.
  always_comb begin
    cnt_o = 5'(W);
    for (int i = 0; i < W; i++) begin
      if (val_i[i]) cnt_o = 5'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp32_add_sub.sv
// Binary32 add/subtract, round-to-nearest-even, flush-to-zero, registered output.
module fp32_add_sub
  import fp32_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  fp32_add_sub_if.slave  bus
);

  fp_unpacked_t ua, ub, lg, sm;
  logic         a_ge, eff_sub;
  logic [7:0]   exp_diff;
  logic [26:0]  lg_ext, sm_raw, sm_sh, sm_ext, dif;
  logic [27:0]  sum;
  logic [4:0]   lz;

  logic [26:0]        mant_n;
  logic signed [9:0]  exp_n, exp_r;
  logic [22:0]        frac_r;
  logic [31:0]        norm_res;
  logic [DATA_WIDTH-1:0] out_d, out_q;

  logic a_exp_max, b_exp_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sb;

  // Round-to-nearest-even on a 24-bit significand with guard/round/sticky below it.
  // Returns the possibly incremented exponent and the 23-bit stored fraction.
  function automatic logic [32:0] round_rne(input logic [26:0] m, input logic signed [9:0] e);
    logic              up;
    logic [24:0]       r;
    logic signed [9:0] eo;
    logic [22:0]       fr;
    up = m[2] & (m[1] | m[0] | m[3]);
    r  = {1'b0, m[26:3]} + {24'b0, up};
    eo = r[24] ? (e + 10'sd1) : e;
    fr = r[24] ? r[23:1] : r[22:0];
    return {eo, fr};
  endfunction

  // Saturate exponents past the finite range to a signed infinity.
  function automatic logic [31:0] pack_sat(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] f);
    if (e >= 10'sd255) return s ? NEG_INF : POS_INF;
    return {s, e[7:0], f};
  endfunction

  assign a_exp_max = &bus.a[30:23];
  assign b_exp_max = &bus.b[30:23];
  assign a_nan     = a_exp_max & (|bus.a[22:0]);
  assign b_nan     = b_exp_max & (|bus.b[22:0]);
  assign a_inf     = a_exp_max & ~(|bus.a[22:0]);
  assign b_inf     = b_exp_max & ~(|bus.b[22:0]);
  assign a_zero    = ~(|bus.a[30:23]);
  assign b_zero    = ~(|bus.b[30:23]);
  assign sb        = bus.b[31] ^ bus.symbol;

  // Unpack, order by magnitude, align the smaller operand, form sum and difference.
  always_comb begin
    ua       = unpack(bus.a, 1'b0);
    ub       = unpack(bus.b, bus.symbol);
    a_ge     = bus.a[30:0] >= bus.b[30:0];
    lg       = a_ge ? ua : ub;
    sm       = a_ge ? ub : ua;
    exp_diff = lg.exp - sm.exp;
    lg_ext   = {lg.sig, 3'b000};
    sm_raw   = {sm.sig, 3'b000};
    sm_sh    = sm_raw >> exp_diff;
    if (exp_diff >= 8'd26) sm_ext = 27'd1;
    else sm_ext = {sm_sh[26:1], sm_sh[0] | (|(sm_raw & ((27'd1 << exp_diff) - 27'd1)))};
    eff_sub  = lg.sign ^ sm.sign;
    sum      = {1'b0, lg_ext} + {1'b0, sm_ext};
    dif      = lg_ext - sm_ext;
  end

  lzc24 #(.W(27)) u_lzc (
    .val_i (dif),
    .cnt_o (lz)
  );

  // Normalize, round, then let special operands override the arithmetic result.
  always_comb begin
    if (eff_sub) begin
      mant_n = dif << lz;
      exp_n  = $signed({2'b00, lg.exp}) - $signed({5'b00000, lz});
    end else if (sum[27]) begin
      mant_n = {sum[27:2], sum[1] | sum[0]};
      exp_n  = $signed({2'b00, lg.exp}) + 10'sd1;
    end else begin
      mant_n = sum[26:0];
      exp_n  = $signed({2'b00, lg.exp});
    end
    {exp_r, frac_r} = round_rne(mant_n, exp_n);

    if (eff_sub && (dif == 27'd0)) norm_res = 32'h0000_0000;
    else if (exp_n <= 10'sd0)      norm_res = {lg.sign, 31'b0};
    else                           norm_res = pack_sat(lg.sign, exp_r, frac_r);

    if (a_nan || b_nan)         out_d = QNAN;
    else if (a_inf && b_inf)    out_d = (bus.a[31] == sb) ? bus.a : QNAN;
    else if (a_inf)             out_d = bus.a;
    else if (b_inf)             out_d = {sb, bus.b[30:0]};
    else if (a_zero && b_zero)  out_d = {bus.a[31] & sb, 31'b0};
    else if (a_zero)            out_d = {sb, bus.b[30:0]};
    else if (b_zero)            out_d = bus.a;
    else                        out_d = norm_res;
  end

  // Output register; reset wins over a new result.
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_fp32_add_sub.sv
// Bench for fp32_add_sub: directed cases plus random operands against a real-arithmetic model.
module tb_fp32_add_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  fp32_add_sub_if #(.DATA_WIDTH(32)) bus ();

  fp32_add_sub #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Binary32 operand to double bits, with subnormals flushed to signed zero.
  function automatic logic [63:0] to_dbits(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'hFF) return {x[31], 11'h7FF, x[22:0], 29'b0};
    if (x[30:23] == 8'h00) return {x[31], 63'b0};
    e = 11'(x[30:23]) + 11'd896;
    return {x[31], e, x[22:0], 29'b0};
  endfunction

  // Double result to binary32: RNE on the 53-bit significand, FTZ, overflow to inf.
  function automatic logic [31:0] from_dbits(input logic [63:0] d);
    int          e;
    logic [24:0] m;
    logic [28:0] rem;
    if (d[62:52] == 11'h7FF) return (d[51:0] != 0) ? 32'h7FC0_0000 : {d[63], 8'hFF, 23'b0};
    if (d[62:52] == 11'h000) return {d[63], 31'b0};
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 31'b0};
    m   = {2'b01, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sym);
    real ra, rb;
    ra = $bitstoreal(to_dbits(a));
    rb = $bitstoreal(to_dbits({b[31] ^ sym, b[30:0]}));
    return from_dbits($realtobits(ra + rb));
  endfunction

  // Random operand whose exponent clusters around e0, with occasional specials.
  function automatic logic [31:0] rnd_fp(input int e0);
    int   k, e;
    logic s;
    logic [22:0] f;
    k = int'($urandom_range(0, 19));
    s = 1'($urandom);
    f = 23'($urandom);
    if (k == 0) return {s, 8'h00, f};
    if (k == 1) return {s, 8'hFF, 23'b0};
    if (k == 2) return {s, 8'hFF, f | 23'h1};
    e = e0 + int'($urandom_range(0, 60)) - 30;
    if (e < 1)   e = 1;
    if (e > 254) e = 254;
    return {s, 8'(e), f};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: out=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sym, input logic [31:0] exp);
    @(negedge clk);
    bus.a      = a;
    bus.b      = b;
    bus.symbol = sym;
    @(posedge clk);
    #1;
    check(tag, bus.out, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    bus.a      = 32'h40A0_0000;
    bus.b      = 32'h40E0_0000;
    bus.symbol = 1'b0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", bus.out, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_5_7",      32'h40A0_0000, 32'h40E0_0000, 1'b0, 32'h4140_0000);
    @(negedge clk);
    bus.a = 32'h7FC0_0000;
    bus.b = 32'h1234_5678;
    #1;
    check("hold_between_edges", bus.out, 32'h4140_0000);
    run_op("sub_5_7",      32'h40A0_0000, 32'h40E0_0000, 1'b1, 32'hC000_0000);
    run_op("zero_plus",    32'h0000_0000, 32'h406C_CCCD, 1'b0, 32'h406C_CCCD);
    run_op("neg_sub_rnd",  32'hC179_999A, 32'h406C_CCCD, 1'b1, 32'hC19A_6667);
    run_op("neg_add_rnd",  32'hC179_999A, 32'hC06C_CCCD, 1'b0, 32'hC19A_6667);
    run_op("cancel",       32'h3EC0_0000, 32'h3EC0_0000, 1'b1, 32'h0000_0000);
    run_op("inf_sub_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000);
    run_op("overflow",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
    run_op("inf_add_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000);
    run_op("inf_finite",   32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000);
    run_op("nan_in",       32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000);
    run_op("pz_plus_nz",   32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000);
    run_op("nz_plus_nz",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
    run_op("zero_minus",   32'h0000_0000, 32'h406C_CCCD, 1'b1, 32'hC06C_CCCD);
    run_op("subnorm_ftz",  32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000);
    run_op("underflow",    32'h8080_0001, 32'h0080_0000, 1'b0, 32'h8000_0000);
    run_op("tie_even",     32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
    run_op("tie_odd_up",   32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002);

    @(negedge clk);
    bus.a      = 32'h40A0_0000;
    bus.b      = 32'h40E0_0000;
    bus.symbol = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid", bus.out, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset", bus.out, 32'h4140_0000);

    for (int i = 0; i < 600; i++) begin
      int e0;
      e0 = int'($urandom_range(1, 254));
      ra = rnd_fp(e0);
      rb = ($urandom_range(0, 9) == 0) ? ra : rnd_fp(e0);
      rs = 1'($urandom);
      run_op($sformatf("rand%0d_%08h_%08h_%0d", i, ra, rb, rs), ra, rb, rs,
             ref_model(ra, rb, rs));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
